// File: rtl/sum_acc_pkg.sv
// Shared types and sizing helpers for the sum accumulator.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Total width: one sum is width+1 bits, a group of count adds log2(count) bits.
    function automatic int acc_width(input int width, input int count);
        return width + 1 + $clog2(count);
    endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Sums groups of COUNT accepted adder samples, presents total and mean; result one cycle after the last accept.
// Backpressure: result holds while i_ready is low, and o_sum_ready stays low until the result is handed off.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    localparam int ACC_W = acc_width(WIDTH, COUNT),
    localparam int CNT_W = $clog2(COUNT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH:0]   i_sum,
    input  logic             i_sum_valid,
    output logic             o_sum_ready,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_total,
    output logic [WIDTH:0]   o_mean,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt
);

    if (COUNT < 2 || (COUNT & (COUNT - 1)) != 0) begin : g_bad_count
        $error("sum_accumulator: COUNT must be a power of two and at least 2");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   total_q, total_d;
    logic [WIDTH:0]     mean_q, mean_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic [ACC_W-1:0]   acc_next;

    assign o_sum_ready = (state_q == ACCUM);
    assign accept      = i_sum_valid & o_sum_ready;
    assign acc_next    = acc_q + ACC_W'(i_sum);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        mean_d  = mean_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: state_d = ACCUM;
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(COUNT - 1)) begin
                        total_d = acc_next;
                        // Dividing by a power of two is just dropping the low count bits.
                        mean_d  = acc_next[ACC_W-1:CNT_W];
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over accept and handoff; the last published total/mean survive it.
        if (i_clear && state_q != IDLE) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            total_d = total_q;
            mean_d  = mean_q;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            mean_q  <= mean_d;
            valid_q <= valid_d;
        end
    end

    assign o_total = total_q;
    assign o_mean  = mean_q;
    assign o_valid = valid_q;
    assign o_cnt   = cnt_q;

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the registered adder stage.
- Takes the WIDTH+1-bit sums and adds up groups of COUNT accepted samples.
- Presents each group's total and mean on a valid/ready output that holds under backpressure.
- Sits between the adder and the statistics/output logic. It supplies the flow control (i_sum_valid/o_sum_ready) that the adder's plain registered output lacks.

Parameters:
- WIDTH, 8, operand width of the upstream adder; input sum is WIDTH+1 bits.
- COUNT, 4, samples per group; must be a power of two, ≥2 (elaboration-time check).
- ACC_W, WIDTH+1+$clog2(COUNT), localparam; accumulator/total width, sized so overflow is impossible.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sum  input  WIDTH+1  sample from the adder stage.
- i_sum_valid  input  1  i_sum is valid this cycle.
- o_sum_ready  output  1  block accepts a sample this cycle.
- i_clear  input  1  synchronous clear of partial group and pending result.
- o_total  output  ACC_W  sum of the last completed group.
- o_mean  output  WIDTH+1  o_total >> $clog2(COUNT), truncating.
- o_valid  output  1  o_total/o_mean valid.
- i_ready  input  1  downstream accepts the result.
- o_cnt  output  $clog2(COUNT)  samples accepted in the current group.

Behaviour:
- Reset is asynchronous and active-low on i_rst_n; clock is i_clk. While reset is asserted:
  - state=IDLE; acc, o_cnt, o_total, o_mean all 0;
  - o_valid=0, o_sum_ready=0.
- Transfer rules:
  - Accept = i_sum_valid & o_sum_ready.
  - Result handoff = o_valid & i_ready.
- o_sum_ready is 1 only in ACCUM (decoded from registered state).
- FSM states:
  - IDLE: entered only by reset. Goes to ACCUM on the first clock edge after i_rst_n deasserts, unconditionally.
  - ACCUM: on each accept, acc <= acc + i_sum and o_cnt increments. On the accept that makes COUNT samples, at that same edge:
    - o_total <= acc + i_sum and o_mean <= (acc + i_sum) >> log2(COUNT);
    - o_valid <= 1; acc <= 0; o_cnt <= 0; state <= HOLD.
    - Latency: result visible the cycle after the COUNT-th accept.
  - HOLD: o_sum_ready=0; o_total/o_mean/o_valid stay stable until handoff. On handoff, o_valid <= 0 and state <= ACCUM. No sample is accepted in the handoff cycle.
- Throughput: best case COUNT+1 cycles per result.
- Gaps in i_sum_valid: only accepted cycles count; acc and o_cnt hold otherwise.
- i_clear has highest priority over accept and handoff. Effect at the edge:
  - acc <= 0, o_cnt <= 0, o_valid <= 0, state <= ACCUM;
  - o_total/o_mean keep their last value;
  - a sample presented in the i_clear cycle is discarded, even though o_sum_ready may read 1.
- i_clear in IDLE: ignored; normal IDLE→ACCUM transition.
- Width rules:
  - i_sum is zero-extended to ACC_W; unsigned arithmetic throughout.
  - Maximum total is COUNT*(2^(WIDTH+1)-2), which always fits ACC_W.
- Reset mid-group or mid-HOLD: everything clears immediately (asynchronous); a pending result is lost.
- o_valid never drops without a handoff, except on i_clear or reset.

Decomposition:
- Package sum_acc_pkg holds:
  - the FSM state typedef (IDLE, ACCUM, HOLD, 2-bit encoding);
  - a function computing ACC_W from WIDTH and COUNT.
- Single module; no sub-module. Counter and accumulator are trivial inline registers.
- Estimated 150–200 lines of RTL.

Test Plan:
- Reset, WIDTH=8, COUNT=4:
  - during reset: o_valid=0, o_total=0, o_sum_ready=0;
  - first cycle after release: o_sum_ready=0; second cycle: o_sum_ready=1.
- Back-to-back samples 10,20,30,40 with i_ready=1 → one cycle after the 4th accept: o_total=100, o_mean=25, o_valid=1 for exactly one cycle; then o_sum_ready=1 again.
- Four samples of 510 → o_total=2040 (11 bits, no wrap), o_mean=510.
- Backpressure: after group 1,2,3,4, hold i_ready=0 for 5 cycles →
  - o_valid=1, o_total=10, o_mean=2 stable throughout;
  - o_sum_ready=0, so the upstream sample 7 is held, not lost;
  - after i_ready=1, sample 7 is accepted first with o_cnt=1.
- Sparse valid: samples 5,(gap 3 cycles),5,5,(gap),5 → o_total=20, o_cnt steps 1,2,3 only on accepts.
- i_clear after samples 100,100, then samples 1,2,3,4 → o_total=10. Separately, assert i_rst_n=0 while in HOLD → o_valid falls without waiting for a clock edge.
